// File: rtl/fetch_pkg.sv
// Shared definitions for the PC/fetch sequencer: FSM state encoding,
// the sequential PC stride and default datapath widths.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        FULL   = 3'd3,
        HALTED = 3'd4
    } fetch_state_e;

    localparam int unsigned PC_INCR     = 4;
    localparam int unsigned DEF_ADDR_W  = 64;
    localparam int unsigned DEF_INSTR_W = 32;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register for one fetched instruction and its PC,
// presented to decode with valid/ready; flush wins over load and dequeue.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               deq_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] data_q,  data_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (deq_i && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the architectural PC and sequences single-outstanding instruction
// fetches into a one-entry decode buffer, squashing wrong-path responses.
module pc_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  fetch_pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              squash_q, squash_d;
    logic              buf_load, buf_flush;
    logic              req_hs;
    logic [ADDR_W-1:0] redirect_pc;

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign fetch_pc       = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign redirect_pc    = redirect_target & ~ADDR_W'(3);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        squash_d  = squash_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = halt ? HALTED : REQ;
            end
            REQ: begin
                if (req_hs) begin
                    state_d  = WAIT;
                    // A redirect racing the accepted request makes its response stale.
                    squash_d = redirect_valid;
                end else if (halt) begin
                    state_d = HALTED;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (squash_q || redirect_valid) begin
                        squash_d = 1'b0;
                        state_d  = halt ? HALTED : REQ;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + ADDR_W'(PC_INCR);
                        state_d  = FULL;
                    end
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end
            end
            FULL: begin
                if (redirect_valid) begin
                    buf_flush = 1'b1;
                    state_d   = halt ? HALTED : REQ;
                end else if (instr_ready) begin
                    state_d = halt ? HALTED : REQ;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Redirect overrides any sequential PC advance in the same cycle.
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_fetch_buffer (
        .clk_i  (CLK),
        .rst_i  (Reset),
        .load_i (buf_load),
        .flush_i(buf_flush),
        .deq_i  (instr_ready),
        .data_i (imem_resp_data),
        .pc_i   (pc_q),
        .valid_o(instr_valid),
        .data_o (instr_data),
        .pc_o   (instr_pc)
    );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequential fetch, decode stall,
// redirects in WAIT/FULL, halt, mid-fetch reset and PC wrap-around.
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        halt;

    logic        req_valid, instr_valid;
    logic [63:0] req_addr, instr_pc, fetch_pc;
    logic [31:0] instr_data;

    logic        w_req_valid, w_instr_valid;
    logic [63:0] w_req_addr, w_instr_pc, w_fetch_pc;
    logic [31:0] w_instr_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pc_fetch_sequencer #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
        .CLK(CLK), .Reset(Reset),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .fetch_pc(fetch_pc)
    );

    pc_fetch_sequencer #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .CLK(CLK), .Reset(Reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr_data(w_instr_data), .instr_pc(w_instr_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .fetch_pc(w_fetch_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // From REQ with addr exp_pc: handshake, respond next cycle, land in FULL.
    task automatic fetch_one(input string tag, input logic [31:0] data, input logic [63:0] exp_pc);
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd1);
        chk({tag, "_req_addr"}, req_addr, exp_pc);
        step();
        chk({tag, "_wait_req_valid"}, 64'(req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        chk({tag, "_instr_valid"}, 64'(instr_valid), 64'd1);
        chk({tag, "_instr_data"}, 64'(instr_data), 64'(data));
        chk({tag, "_instr_pc"}, instr_pc, exp_pc);
        chk({tag, "_fetch_pc"}, fetch_pc, exp_pc + 64'd4);
    endtask

    initial begin
        Reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        halt            = 1'b0;

        step();
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr_data", 64'(instr_data), 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);
        chk("rst_fetch_pc", fetch_pc, 64'd0);
        chk("rst_wrap_fetch_pc", w_fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        Reset = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        chk("idle_req_valid", 64'(req_valid), 64'd0);
        step();

        // Back-to-back sequential fetches, one every three cycles
        chk("wrap_first_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one("f0", 32'hA000_0000, 64'h0);
        step();
        chk("wrap_second_addr", w_req_addr, 64'h0);
        chk("wrap_second_valid", 64'(w_req_valid), 64'd1);
        fetch_one("f1", 32'hA000_0001, 64'h4);
        step();

        // Decode stall while FULL
        instr_ready = 1'b0;
        fetch_one("f2", 32'hA000_0002, 64'h8);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_data", 64'(instr_data), 64'hA000_0002);
            chk("stall_pc", instr_pc, 64'h8);
            chk("stall_no_req", 64'(req_valid), 64'd0);
        end
        instr_ready = 1'b1;
        step();
        chk("release_instr_valid", 64'(instr_valid), 64'd0);
        chk("release_req_valid", 64'(req_valid), 64'd1);
        chk("release_req_addr", req_addr, 64'hC);

        // Redirect during WAIT squashes the in-flight response
        step();
        redirect_valid  = 1'b1;
        redirect_target = 64'h1003;
        step();
        redirect_valid  = 1'b0;
        chk("rdw_fetch_pc", fetch_pc, 64'h1000);
        chk("rdw_req_valid", 64'(req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        chk("rdw_dropped", 64'(instr_valid), 64'd0);
        chk("rdw_req_valid2", 64'(req_valid), 64'd1);
        chk("rdw_req_addr", req_addr, 64'h1000);

        // Redirect in FULL without decode accept: flush
        instr_ready = 1'b0;
        fetch_one("f3", 32'hA000_0003, 64'h1000);
        redirect_valid  = 1'b1;
        redirect_target = 64'h200;
        step();
        redirect_valid  = 1'b0;
        chk("rdf_flushed", 64'(instr_valid), 64'd0);
        chk("rdf_req_valid", 64'(req_valid), 64'd1);
        chk("rdf_req_addr", req_addr, 64'h200);

        // Redirect in FULL with decode accept: delivered once, then refetch
        fetch_one("f4", 32'hA000_0004, 64'h200);
        redirect_valid  = 1'b1;
        redirect_target = 64'h200;
        instr_ready     = 1'b1;
        chk("rdfa_deliver_valid", 64'(instr_valid), 64'd1);
        chk("rdfa_deliver_data", 64'(instr_data), 64'hA000_0004);
        step();
        redirect_valid = 1'b0;
        chk("rdfa_after_valid", 64'(instr_valid), 64'd0);
        chk("rdfa_req_addr", req_addr, 64'h200);

        // Halt in REQ with no handshake
        imem_req_ready = 1'b0;
        halt = 1'b1;
        chk("halt_in_req", 64'(req_valid), 64'd1);
        step();
        chk("halted_no_req", 64'(req_valid), 64'd0);
        step();
        chk("halted_no_req2", 64'(req_valid), 64'd0);
        chk("halted_pc", fetch_pc, 64'h200);
        halt = 1'b0;
        step();
        chk("unhalt_req_valid", 64'(req_valid), 64'd1);
        chk("unhalt_req_addr", req_addr, 64'h200);

        // Asynchronous reset mid-WAIT
        imem_req_ready = 1'b1;
        step();
        chk("prereset_wait", 64'(req_valid), 64'd0);
        #2;
        Reset = 1'b1;
        #1;
        chk("areset_fetch_pc", fetch_pc, 64'h0);
        chk("areset_req_valid", 64'(req_valid), 64'd0);
        chk("areset_instr_valid", 64'(instr_valid), 64'd0);
        step();
        Reset = 1'b0;
        step();
        chk("post_reset_req_addr", req_addr, 64'h0);
        chk("post_reset_req_valid", 64'(req_valid), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
